mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between instruction fetch (IF) and data access (MEM stage).

---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF/MEM requesters and the memory-port arbiter.
// Latency: none, this is wiring only.
// Backpressure: none at this level; requesters hold a level request until their done pulse.
interface mem_port_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   // Requester side
   logic                  if_req;
   logic                  if_kill;
   logic                  d_req;
   logic                  d_we;
   // Memory side
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_sel;
   logic                  mem_req;
   logic                  mem_we;
   // Completion
   logic                  if_done;
   logic                  d_done;
   logic [DATA_WIDTH-1:0] rdata;

   // Requesters and the memory model drive the master side.
   modport master (
      output if_req, if_kill, d_req, d_we, mem_rdata,
      input  mem_sel, mem_req, mem_we, if_done, d_done, rdata
   );

   // The arbiter sits on the slave side.
   modport slave (
      input  if_req, if_kill, d_req, d_we, mem_rdata,
      output mem_sel, mem_req, mem_we, if_done, d_done, rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access; data wins, fetch is starvation-guarded.
// Latency: request sampled in IDLE -> LATENCY ACCESS cycles -> done pulse one cycle later; one IDLE bubble between accesses.
// Backpressure: requests are levels held until done; a request not granted simply waits in IDLE, nothing is dropped.
module mem_port_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int LATENCY      = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Counter reload value and starvation threshold, both held in 4-bit counters.
   localparam logic [3:0] LAT_INIT   = 4'(LATENCY - 1);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t                state_q,      state_d;
   logic                  owner_q,      owner_d;      // 0 = fetch, 1 = data
   logic [3:0]            lat_cnt_q,    lat_cnt_d;
   logic [3:0]            starve_cnt_q, starve_cnt_d;
   logic                  kill_flag_q,  kill_flag_d;
   logic [DATA_WIDTH-1:0] rdata_q,      rdata_d;
   logic                  mem_req_q,    mem_req_d;
   logic                  mem_we_q,     mem_we_d;
   logic                  if_done_q,    if_done_d;
   logic                  d_done_q,     d_done_d;

   logic                  fetch_ok;
   logic                  grant_data;

   // A killed fetch is not a candidate; data wins unless fetch has waited out STARVE_LIMIT data grants.
   assign fetch_ok   = bus.if_req & ~bus.if_kill;
   assign grant_data = bus.d_req & ~(fetch_ok & (starve_cnt_q >= STARVE_MAX));

   // Next-state and next-output logic for the IDLE -> ACCESS -> DONE sequence.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      lat_cnt_d    = lat_cnt_q;
      starve_cnt_d = starve_cnt_q;
      kill_flag_d  = kill_flag_q;
      rdata_d      = rdata_q;
      mem_req_d    = 1'b0;
      mem_we_d     = 1'b0;
      if_done_d    = 1'b0;
      d_done_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            kill_flag_d = 1'b0;
            if (bus.d_req || fetch_ok) begin
               // owner only moves here, so mem_sel is steady through ACCESS and DONE.
               owner_d   = grant_data;
               lat_cnt_d = LAT_INIT;
               state_d   = ST_ACCESS;
               mem_req_d = 1'b1;
               mem_we_d  = grant_data & bus.d_we;
               if (grant_data) begin
                  if (fetch_ok) begin
                     if (starve_cnt_q != 4'hF) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                     end
                  end else if (!bus.if_req) begin
                     starve_cnt_d = 4'd0;
                  end
               end else begin
                  starve_cnt_d = 4'd0;
               end
            end
         end

         ST_ACCESS: begin
            // A flush during a fetch cannot abort the memory cycle, only its completion report.
            if (!owner_q && bus.if_kill) begin
               kill_flag_d = 1'b1;
            end
            if (lat_cnt_q == 4'd0) begin
               if (!(owner_q && bus.d_we)) begin
                  rdata_d = bus.mem_rdata;
               end
               state_d   = ST_DONE;
               if_done_d = ~owner_q & ~kill_flag_q & ~bus.if_kill;
               d_done_d  = owner_q;
            end else begin
               lat_cnt_d = lat_cnt_q - 4'd1;
               mem_req_d = 1'b1;
               mem_we_d  = owner_q & bus.d_we;
            end
         end

         ST_DONE: begin
            // The done pulse is already registered; a kill arriving now is too late to retract it,
            // so the flag is simply dropped as we return to IDLE.
            kill_flag_d = 1'b0;
            state_d     = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; synchronous reset aborts any access without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         lat_cnt_q    <= 4'd0;
         starve_cnt_q <= 4'd0;
         kill_flag_q  <= 1'b0;
         rdata_q      <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         if_done_q    <= 1'b0;
         d_done_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         kill_flag_q  <= kill_flag_d;
         rdata_q      <= rdata_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         if_done_q    <= if_done_d;
         d_done_q     <= d_done_d;
      end
   end

   assign bus.mem_sel = owner_q;
   assign bus.mem_req = mem_req_q;
   assign bus.mem_we  = mem_we_q;
   assign bus.if_done = if_done_q;
   assign bus.d_done  = d_done_q;
   assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a completion scoreboard.
// Latency: checks cycle-exact strobe/done timing for LATENCY=2.
// Backpressure: requesters hold levels until done, as the arbiter expects.
module tb_mem_port_arbiter;
   localparam int DW  = 32;
   localparam int LAT = 2;
   localparam int SL  = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.DATA_WIDTH(DW)) bus ();

   mem_port_arbiter #(
      .DATA_WIDTH   (DW),
      .LATENCY      (LAT),
      .STARVE_LIMIT (SL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic          is_data;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic is_data, input logic [DW-1:0] rd);
      exp_t e;
      e.is_data = is_data;
      e.rdata   = rd;
      sb.push_back(e);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Completion monitor: every done pulse must match the oldest expected completion.
   always @(negedge clk) begin
      if (!reset && (bus.if_done || bus.d_done)) begin
         exp_t e;
         chk("both_done", {31'd0, bus.if_done & bus.d_done}, 32'd0);
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected: observed if_done=%0b d_done=%0b expected no completion",
                   bus.if_done, bus.d_done);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_owner", {31'd0, bus.d_done}, {31'd0, e.is_data});
            chk("sb_rdata", bus.rdata, e.rdata);
         end
      end
   end

   initial begin
      reset         = 1'b1;
      bus.if_req    = 1'b0;
      bus.if_kill   = 1'b0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.mem_rdata = 32'hFFFF_FFFF;
      tick();
      tick();
      // Reset state
      chk("rst_mem_sel", {31'd0, bus.mem_sel}, 32'd0);
      chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("rst_mem_we",  {31'd0, bus.mem_we},  32'd0);
      chk("rst_if_done", {31'd0, bus.if_done}, 32'd0);
      chk("rst_d_done",  {31'd0, bus.d_done},  32'd0);
      chk("rst_rdata",   bus.rdata,            32'd0);
      reset = 1'b0;
      tick();

      // 1: fetch only; rdata must come from the last ACCESS cycle, not the first.
      bus.if_req    = 1'b1;
      bus.mem_rdata = 32'hAAAA_0000;
      push(1'b0, 32'h0000_0013);
      tick();                                   // edge 0 -> cycle 1
      chk("t1_req_c1", {31'd0, bus.mem_req}, 32'd1);
      chk("t1_sel",    {31'd0, bus.mem_sel}, 32'd0);
      chk("t1_we",     {31'd0, bus.mem_we},  32'd0);
      tick();                                   // cycle 2
      chk("t1_req_c2", {31'd0, bus.mem_req}, 32'd1);
      bus.mem_rdata = 32'h0000_0013;
      tick();                                   // cycle 3
      chk("t1_done",   {31'd0, bus.if_done}, 32'd1);
      chk("t1_rdata",  bus.rdata,            32'h0000_0013);
      chk("t1_req_c3", {31'd0, bus.mem_req}, 32'd0);
      bus.if_req = 1'b0;
      tick();                                   // cycle 4, IDLE
      chk("t1_done_c4", {31'd0, bus.if_done}, 32'd0);

      // 2: simultaneous requests, data first, then fetch.
      bus.if_req    = 1'b1;
      bus.d_req     = 1'b1;
      bus.d_we      = 1'b0;
      bus.mem_rdata = 32'hDEAD_BEEF;
      push(1'b1, 32'hDEAD_BEEF);
      push(1'b0, 32'h0000_1111);
      tick();                                   // cycle 1
      chk("t2_sel_data", {31'd0, bus.mem_sel}, 32'd1);
      chk("t2_req",      {31'd0, bus.mem_req}, 32'd1);
      tick();
      tick();                                   // cycle 3
      chk("t2_d_done",   {31'd0, bus.d_done},  32'd1);
      chk("t2_if_done",  {31'd0, bus.if_done}, 32'd0);
      bus.d_req     = 1'b0;
      bus.mem_rdata = 32'h0000_1111;
      tick();                                   // cycle 4, IDLE
      chk("t2_idle_req", {31'd0, bus.mem_req}, 32'd0);
      chk("t2_sel_hold", {31'd0, bus.mem_sel}, 32'd1);
      tick();                                   // cycle 5, fetch granted at edge 4
      chk("t2_sel_fetch", {31'd0, bus.mem_sel}, 32'd0);
      chk("t2_req_f",     {31'd0, bus.mem_req}, 32'd1);
      tick();
      tick();                                   // cycle 7
      chk("t2_if_done7",  {31'd0, bus.if_done}, 32'd1);
      bus.if_req = 1'b0;
      tick();

      // 3: starvation guard, both requests held.
      bus.if_req = 1'b1;
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      for (int i = 0; i < SL; i++) begin
         bus.mem_rdata = 32'h100 + 32'(i);
         push(1'b1, 32'h100 + 32'(i));
         tick();                                // grant edge
         chk("t3_sel_data", {31'd0, bus.mem_sel}, 32'd1);
         tick();
         tick();                                // DONE
         tick();                                // IDLE
      end
      chk("t3_starve_full", {28'd0, dut.starve_cnt_q}, 32'(SL));
      bus.mem_rdata = 32'h200;
      push(1'b0, 32'h200);
      tick();                                   // 5th arbitration
      chk("t3_sel_forced", {31'd0, bus.mem_sel}, 32'd0);
      chk("t3_starve_clr", {28'd0, dut.starve_cnt_q}, 32'd0);
      tick();
      tick();                                   // DONE
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      tick();

      // 4: write, rdata keeps the previous read value.
      bus.d_req     = 1'b1;
      bus.d_we      = 1'b1;
      bus.mem_rdata = 32'h0BAD_0BAD;
      push(1'b1, 32'h200);
      tick();
      chk("t4_we_c1",  {31'd0, bus.mem_we},  32'd1);
      chk("t4_sel",    {31'd0, bus.mem_sel}, 32'd1);
      tick();
      chk("t4_we_c2",  {31'd0, bus.mem_we},  32'd1);
      tick();                                   // DONE
      chk("t4_we_done",  {31'd0, bus.mem_we},  32'd0);
      chk("t4_req_done", {31'd0, bus.mem_req}, 32'd0);
      chk("t4_rdata",    bus.rdata,            32'h200);
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      tick();

      // 5: kill in cycle 2 of a fetch; access completes silently, rdata still updates.
      bus.if_req    = 1'b1;
      bus.mem_rdata = 32'h55;
      tick();                                   // cycle 1
      chk("t5_req_c1", {31'd0, bus.mem_req}, 32'd1);
      tick();                                   // cycle 2
      chk("t5_req_c2", {31'd0, bus.mem_req}, 32'd1);
      bus.if_kill = 1'b1;
      tick();                                   // cycle 3
      chk("t5_no_done", {31'd0, bus.if_done}, 32'd0);
      chk("t5_req_c3",  {31'd0, bus.mem_req}, 32'd0);
      chk("t5_rdata",   bus.rdata,            32'h55);
      bus.if_kill = 1'b0;
      bus.if_req  = 1'b0;
      tick();                                   // cycle 4, must be IDLE
      chk("t5_req_c4",  {31'd0, bus.mem_req}, 32'd0);

      // 6: IDLE in cycle 4 means a data request now is granted at once; reset it mid-access.
      bus.d_req = 1'b1;
      bus.d_we  = 1'b0;
      tick();
      chk("t6_req_start", {31'd0, bus.mem_req}, 32'd1);
      reset = 1'b1;
      tick();
      chk("t6_req",     {31'd0, bus.mem_req}, 32'd0);
      chk("t6_sel",     {31'd0, bus.mem_sel}, 32'd0);
      chk("t6_we",      {31'd0, bus.mem_we},  32'd0);
      chk("t6_d_done",  {31'd0, bus.d_done},  32'd0);
      chk("t6_if_done", {31'd0, bus.if_done}, 32'd0);
      chk("t6_rdata",   bus.rdata,            32'd0);
      reset     = 1'b0;
      bus.d_req = 1'b0;
      tick();
      tick();
      tick();

      // 7: normal fetch after reset completes with a done pulse.
      bus.if_req    = 1'b1;
      bus.mem_rdata = 32'h77;
      push(1'b0, 32'h77);
      tick();
      tick();
      tick();
      chk("t7_done", {31'd0, bus.if_done}, 32'd1);
      bus.if_req = 1'b0;
      tick();
      tick();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
